// File: rtl/btn_ctrl_pkg.sv
// Shared types for the button event controller (LONG events exist only with LONG_PRESS_EN).
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_type_e;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } deb_state_e;

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: level FSM plus stable-tick counter; long-press counter
// is built only when LONG_PRESS_EN is defined.
module btn_debounce_ch
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 3
`ifdef LONG_PRESS_EN
  ,
  parameter int unsigned LONG_TICKS   = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       tick,
  output logic       level,
  output logic       post,
  output logic [1:0] post_type
);

  localparam int unsigned SW = cnt_width(STABLE_TICKS);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

  localparam logic [1:0] ST_LOW     = 2'(S_LOW);
  localparam logic [1:0] ST_WAIT_HI = 2'(S_WAIT_HI);
  localparam logic [1:0] ST_HIGH    = 2'(S_HIGH);
  localparam logic [1:0] ST_WAIT_LO = 2'(S_WAIT_LO);

  logic [1:0]    state, state_nxt;
  logic [SW-1:0] cnt, cnt_nxt;
  logic          level_nxt;

`ifdef LONG_PRESS_EN
  localparam int unsigned LW = cnt_width(LONG_TICKS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_TICKS);

  logic [LW-1:0] long_cnt, long_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) long_cnt <= '0;
    else       long_cnt <= long_cnt_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

  // Next state; post is asserted on the same edge the level flips.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    post      = 1'b0;
    post_type = EVT_PRESS;
`ifdef LONG_PRESS_EN
    long_cnt_nxt = long_cnt;
`endif
    case (state)
      ST_LOW: begin
        if (btn) begin
          state_nxt = ST_WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!btn) begin
          state_nxt = ST_LOW;
        end else if (tick) begin
          if (cnt == STABLE_LAST) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            post      = 1'b1;
            post_type = EVT_PRESS;
`ifdef LONG_PRESS_EN
            long_cnt_nxt = '0;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (!btn) begin
          state_nxt = ST_WAIT_LO;
          cnt_nxt   = '0;
        end
`ifdef LONG_PRESS_EN
        // Saturated counter stays put until the next PRESS re-arms it.
        else if (tick && (long_cnt != LONG_SAT)) begin
          if (long_cnt == LONG_LAST) begin
            long_cnt_nxt = LONG_SAT;
            post         = 1'b1;
            post_type    = EVT_LONG;
          end else begin
            long_cnt_nxt = long_cnt + 1'b1;
          end
        end
`endif
      end
      ST_WAIT_LO: begin
        if (btn) begin
          state_nxt = ST_HIGH;
        end else if (tick) begin
          if (cnt == STABLE_LAST) begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
            post      = 1'b1;
            post_type = EVT_RELEASE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounced multi-button event source with round-robin valid/ready event port.
// Define LONG_PRESS_EN to enable LONG events after LONG_TICKS ticks held.
module btn_event_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 2,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned LONG_TICKS   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn,
  output logic [N_BTN-1:0]         level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_type,
  output logic                     evt_drop
);

  localparam int unsigned ID_W = $clog2(N_BTN);

  if (N_BTN < 2 || TICK_DIV < 1 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_cfg
    $error("btn_event_ctrl: unsupported parameter set");
  end

  logic [TICK_DIV-1:0] pre_cnt;
  logic                tick;

  logic [N_BTN-1:0] post;
  logic [1:0]       post_type [N_BTN];
  logic [N_BTN-1:0] pend_valid;
  logic [1:0]       pend_type [N_BTN];
  logic [N_BTN-1:0] drop_hit;
  logic [N_BTN-1:0] gnt_mask;

  logic            load, found, grant;
  logic [ID_W-1:0] gnt_id, rr_ptr;
  int unsigned     idx;

  // Shared prescaler: one tick every 2**TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) pre_cnt <= '0;
    else       pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == '0);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef LONG_PRESS_EN
      ,
      .LONG_TICKS  (LONG_TICKS)
`endif
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn[i]),
      .tick     (tick),
      .level    (level[i]),
      .post     (post[i]),
      .post_type(post_type[i])
    );

    // A new post always wins the slot; the arbiter has already copied the old entry if granted.
    always_ff @(posedge clk) begin
      if (reset) begin
        pend_valid[i] <= 1'b0;
        pend_type[i]  <= EVT_PRESS;
      end else if (post[i]) begin
        pend_valid[i] <= 1'b1;
        pend_type[i]  <= post_type[i];
      end else if (gnt_mask[i]) begin
        pend_valid[i] <= 1'b0;
      end
    end

    assign drop_hit[i] = post[i] & pend_valid[i] & ~gnt_mask[i];
  end

  // Round-robin search from rr_ptr over the registered pending slots.
  always_comb begin
    load   = !evt_valid || evt_ready;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx = (32'(rr_ptr) + k) % N_BTN;
      if (!found && pend_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
    grant = found && load;
  end

  assign gnt_mask = grant ? (N_BTN'(1) << gnt_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EVT_PRESS;
      evt_drop  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      evt_drop <= |drop_hit;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id   <= gnt_id;
          evt_type <= pend_type[gnt_id];
          rr_ptr   <= (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with default parameters; LONG expectations follow LONG_PRESS_EN.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_drop;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int drops  = 0;

  typedef struct {
    int id;
    int typ;
    int at;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    int         n;
    logic [3:0] lvl;
    logic       v;
    int         id;
    int         typ;
  } vec_t;
  vec_t vt[10];

  logic       prev_stall = 1'b0;
  logic [1:0] prev_id    = '0;
  logic [1:0] prev_type  = '0;

  always #5 clk = ~clk;

  btn_event_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .level    (level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_type (evt_type),
    .evt_drop (evt_drop)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Inputs are set at a negedge before calling; each iteration logs what the next posedge sees.
  task automatic step(input int n);
    repeat (n) begin
      if (prev_stall && !reset) begin
        chk("hold_valid", int'(evt_valid), 1);
        chk("hold_id", int'(evt_id), int'(prev_id));
        chk("hold_type", int'(evt_type), int'(prev_type));
      end
      if (evt_valid && evt_ready && !reset)
        evq.push_back('{id: int'(evt_id), typ: int'(evt_type), at: cyc});
      if (evt_drop && !reset) drops++;
      prev_stall = evt_valid && !evt_ready && !reset;
      prev_id    = evt_id;
      prev_type  = evt_type;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn       = '0;
    evt_ready = 1'b1;
    step(3);
    reset      = 1'b0;
    prev_stall = 1'b0;
    evq.delete();
    drops = 0;
  endtask

  task automatic chk_ev(input string name, input int k, input int id, input int typ);
    if (k < evq.size()) begin
      chk($sformatf("%s_id%0d", name, k), evq[k].id, id);
      chk($sformatf("%s_type%0d", name, k), evq[k].typ, typ);
    end else begin
      chk($sformatf("%s_missing%0d", name, k), evq.size(), k + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int max_lvl0;
    int ids_a[14];
    int typ_a[14];

    // Clean press/release on btn[1] then a short glitch on btn[0]; cycle counts from first edge after reset.
    vt[0] = '{4'b0010, 1'b1, 12, 4'b0000, 1'b0, 0, 0};
    vt[1] = '{4'b0010, 1'b1,  1, 4'b0010, 1'b0, 0, 0};
    vt[2] = '{4'b0010, 1'b1,  1, 4'b0010, 1'b1, 1, 0};
    vt[3] = '{4'b0010, 1'b1,  1, 4'b0010, 1'b0, 0, 0};
    vt[4] = '{4'b0000, 1'b1,  9, 4'b0010, 1'b0, 0, 0};
    vt[5] = '{4'b0000, 1'b1,  1, 4'b0000, 1'b0, 0, 0};
    vt[6] = '{4'b0000, 1'b1,  1, 4'b0000, 1'b1, 1, 1};
    vt[7] = '{4'b0000, 1'b1,  1, 4'b0000, 1'b0, 0, 0};
    vt[8] = '{4'b0001, 1'b1,  6, 4'b0000, 1'b0, 0, 0};
    vt[9] = '{4'b0000, 1'b1, 10, 4'b0000, 1'b0, 0, 0};

    do_reset();
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_type", int'(evt_type), 0);
    chk("rst_drop", int'(evt_drop), 0);

    for (int i = 0; i < 10; i++) begin
      btn       = vt[i].btn;
      evt_ready = vt[i].rdy;
      step(vt[i].n);
      chk($sformatf("vec%0d_level", i), int'(level), int'(vt[i].lvl));
      chk($sformatf("vec%0d_valid", i), int'(evt_valid), int'(vt[i].v));
      if (vt[i].v) begin
        chk($sformatf("vec%0d_id", i), int'(evt_id), vt[i].id);
        chk($sformatf("vec%0d_type", i), int'(evt_type), vt[i].typ);
      end
    end
    chk("table_evt_count", evq.size(), 2);

    // Bounce: btn[0] toggles every 3 cycles, never stable across 3 ticks.
    do_reset();
    max_lvl0 = 0;
    for (int c = 0; c < 40; c++) begin
      btn[0] = ((c / 3) % 2) == 0;
      step(1);
      if (level[0]) max_lvl0 = 1;
    end
    btn = '0;
    step(20);
    chk("bounce_level", max_lvl0, 0);
    chk("bounce_events", evq.size(), 0);

    // Arbitration: pointer 0 -> 0,2,3; a lone ch2 event moves pointer to 3 -> 3,0,2.
    do_reset();
    btn = 4'b1101; step(20);
    btn = 4'b0000; step(20);
    btn = 4'b0100; step(20);
    btn = 4'b0000; step(20);
    btn = 4'b1101; step(20);
    btn = 4'b0000; step(20);
    ids_a = '{0, 2, 3, 0, 2, 3, 2, 2, 3, 0, 2, 3, 0, 2};
    typ_a = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1};
    chk("arb_count", evq.size(), 14);
    for (int k = 0; k < 14; k++) chk_ev("arb", k, ids_a[k], typ_a[k]);
    if (evq.size() == 14) begin
      chk("arb_b2b_1", evq[1].at - evq[0].at, 1);
      chk("arb_b2b_2", evq[2].at - evq[1].at, 1);
      chk("arb_b2b_9", evq[9].at - evq[8].at, 1);
      chk("arb_b2b_10", evq[10].at - evq[9].at, 1);
    end

    // Backpressure: PRESS held in output, RELEASE pending, second PRESS overwrites it.
    do_reset();
    evt_ready = 1'b0;
    btn = 4'b0100; step(20);
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_id", int'(evt_id), 2);
    chk("bp_type", int'(evt_type), 0);
    btn = 4'b0000; step(20);
    chk("bp_no_drop_yet", drops, 0);
    btn = 4'b0100; step(20);
    chk("bp_drop_pulses", drops, 1);
    chk("bp_still_held_id", int'(evt_id), 2);
    chk("bp_still_held_type", int'(evt_type), 0);
    evt_ready = 1'b1;
    step(5);
    chk("bp_count", evq.size(), 2);
    chk_ev("bp", 0, 2, 0);
    chk_ev("bp", 1, 2, 0);
    chk("bp_drained", int'(evt_valid), 0);

    // Reset while an event is held and another is pending.
    do_reset();
    evt_ready = 1'b0;
    btn = 4'b1010; step(20);
    chk("mr_pre_valid", int'(evt_valid), 1);
    chk("mr_pre_id", int'(evt_id), 1);
    reset = 1'b1;
    btn   = 4'b0000;
    step(1);
    chk("mr_valid", int'(evt_valid), 0);
    chk("mr_level", int'(level), 0);
    reset     = 1'b0;
    evt_ready = 1'b1;
    evq.delete();
    step(30);
    chk("mr_no_stale", evq.size(), 0);
    chk("mr_valid_after", int'(evt_valid), 0);

    // Long hold on btn[3].
    do_reset();
    btn = 4'b1000; step(100);
    btn = 4'b0000; step(24);
`ifdef LONG_PRESS_EN
    chk("long_count", evq.size(), 3);
    chk_ev("long", 0, 3, 0);
    chk_ev("long", 1, 3, 2);
    chk_ev("long", 2, 3, 1);
    if (evq.size() == 3) chk("long_delay", evq[1].at - evq[0].at, 64);
`else
    chk("long_count", evq.size(), 2);
    chk_ev("long", 0, 3, 0);
    chk_ev("long", 1, 3, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
